// File: rtl/rsa_pkg.sv
// Shared types for the RSA modular-exponentiation controller: FSM state
// encoding and operand-select codes driven onto the MMM datapath mux.
package rsa_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_PRE_MAP    = 4'd1,
        ST_MAP        = 4'd2,
        ST_POST_MAP   = 4'd3,
        ST_PRE_MMM    = 4'd4,
        ST_MMM        = 4'd5,
        ST_POST_MMM   = 4'd6,
        ST_PRE_REMAP  = 4'd7,
        ST_REMAP      = 4'd8,
        ST_POST_REMAP = 4'd9,
        ST_DONE       = 4'd10
    } state_t;

    localparam logic [1:0] SEL1_MAP   = 2'b00;
    localparam logic [1:0] SEL1_ROUND = 2'b01;
    localparam logic [1:0] SEL1_REMAP = 2'b10;

endpackage

// File: rtl/rsa_modexp_ctrl.sv
// Control FSM for right-to-left square-and-multiply over a bit-serial
// Montgomery multiplier: map phase, one MMM round per exponent bit, remap.
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int unsigned NBITS      = 8,
    parameter int unsigned EXP_WIDTH  = 10,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic                 start,
    input  logic                 abort,
    input  logic [EXP_WIDTH-1:0] expE,
    output logic                 rst_mmm,
    output logic                 ld_a,
    output logic                 ld_r,
    output logic                 lock1,
    output logic                 lock2,
    output logic [1:0]           sel1,
    output logic                 sel2,
    output logic                 busy,
    output logic                 eoc
);

    localparam int unsigned STEP_W  = $clog2(NBITS + 1);
    localparam int unsigned ROUND_W = $clog2(EXP_WIDTH + 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(NBITS);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(EXP_WIDTH - 1);

    state_t                 state, state_nxt;
    logic [STEP_W-1:0]      step_cnt, step_nxt;
    logic [ROUND_W-1:0]     round_cnt, round_nxt;
    logic [EXP_WIDTH-1:0]   exp_reg, exp_nxt;
    logic [EXP_WIDTH-1:0]   exp_shr;
    logic                   step_last;
    logic                   rounds_over;

    assign exp_shr     = exp_reg >> 1;
    assign step_last   = (step_cnt == STEP_LAST);
    assign rounds_over = (round_cnt == ROUND_LAST) || (EARLY_EXIT && (exp_shr == '0));

    // State, counters and exponent shifter; ena freezes everything
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= ST_IDLE;
            step_cnt  <= '0;
            round_cnt <= '0;
            exp_reg   <= '0;
        end else if (ena) begin
            state     <= state_nxt;
            step_cnt  <= step_nxt;
            round_cnt <= round_nxt;
            exp_reg   <= exp_nxt;
        end
    end

    // Next-state and counter update; abort overrides every transition
    always_comb begin
        state_nxt = state;
        step_nxt  = step_cnt;
        round_nxt = round_cnt;
        exp_nxt   = exp_reg;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    exp_nxt   = expE;
                    state_nxt = ST_PRE_MAP;
                end
            end
            ST_PRE_MAP: begin
                step_nxt  = '0;
                state_nxt = ST_MAP;
            end
            ST_MAP: begin
                if (step_last) state_nxt = ST_POST_MAP;
                else           step_nxt  = step_cnt + STEP_W'(1);
            end
            ST_POST_MAP: begin
                round_nxt = '0;
                state_nxt = ST_PRE_MMM;
            end
            ST_PRE_MMM: begin
                step_nxt  = '0;
                state_nxt = ST_MMM;
            end
            ST_MMM: begin
                if (step_last) state_nxt = ST_POST_MMM;
                else           step_nxt  = step_cnt + STEP_W'(1);
            end
            ST_POST_MMM: begin
                exp_nxt   = exp_shr;
                round_nxt = round_cnt + ROUND_W'(1);
                state_nxt = rounds_over ? ST_PRE_REMAP : ST_PRE_MMM;
            end
            ST_PRE_REMAP: begin
                step_nxt  = '0;
                state_nxt = ST_REMAP;
            end
            ST_REMAP: begin
                if (step_last) state_nxt = ST_POST_REMAP;
                else           step_nxt  = step_cnt + STEP_W'(1);
            end
            ST_POST_REMAP: state_nxt = ST_DONE;
            default:       state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            step_nxt  = '0;
            round_nxt = '0;
            exp_nxt   = '0;
        end
    end

    // Datapath controls decoded from state and current exponent bit
    always_comb begin
        rst_mmm = 1'b0;
        ld_a    = 1'b0;
        ld_r    = 1'b0;
        lock1   = 1'b0;
        lock2   = 1'b0;
        sel1    = SEL1_MAP;
        sel2    = 1'b0;
        busy    = 1'b0;
        eoc     = 1'b0;
        unique case (state)
            ST_PRE_MAP, ST_MAP, ST_POST_MAP: begin
                rst_mmm = 1'b1;
                ld_a    = (state == ST_PRE_MAP);
                ld_r    = (state == ST_POST_MAP);
                lock1   = 1'b1;
                lock2   = 1'b1;
                busy    = 1'b1;
            end
            ST_PRE_MMM, ST_MMM, ST_POST_MMM: begin
                rst_mmm = 1'b1;
                ld_a    = (state == ST_PRE_MMM);
                ld_r    = (state == ST_POST_MMM);
                lock1   = exp_reg[0];
                lock2   = 1'b1;
                sel1    = SEL1_ROUND;
                sel2    = 1'b1;
                busy    = 1'b1;
            end
            ST_PRE_REMAP, ST_REMAP, ST_POST_REMAP: begin
                rst_mmm = 1'b1;
                ld_a    = (state == ST_PRE_REMAP);
                ld_r    = (state == ST_POST_REMAP);
                lock1   = 1'b1;
                sel1    = SEL1_REMAP;
                sel2    = 1'b1;
                busy    = 1'b1;
            end
            ST_DONE: begin
                rst_mmm = 1'b1;
                lock1   = 1'b1;
                sel1    = SEL1_REMAP;
                sel2    = 1'b1;
                eoc     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed bench for rsa_modexp_ctrl: one instance without and one with
// early exit, driven from shared inputs.
module tb_rsa_modexp_ctrl;

    localparam int unsigned NB = 8;
    localparam int unsigned EW = 4;

    // {rst_mmm, ld_a, ld_r, lock1, lock2, sel1[1:0], sel2, busy, eoc}
    localparam logic [9:0] V_IDLE    = 10'b0_0_0_0_0_00_0_0_0;
    localparam logic [9:0] V_PRE_MAP = 10'b1_1_0_1_1_00_0_1_0;
    localparam logic [9:0] V_DONE    = 10'b1_0_0_1_0_10_1_0_1;

    logic          clk = 1'b0;
    logic          rstb, ena, start, abort;
    logic [EW-1:0] expE;

    logic       a_rst_mmm, a_ld_a, a_ld_r, a_lock1, a_lock2, a_sel2, a_busy, a_eoc;
    logic       b_rst_mmm, b_ld_a, b_ld_r, b_lock1, b_lock2, b_sel2, b_busy, b_eoc;
    logic [1:0] a_sel1, b_sel1;
    logic [9:0] ov_a, ov_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [EW-1:0] e;
        bit            ee;
        int            lat;
        int            ldr;
        logic [3:0]    pat;
        int            ena_at;
        int            bstart_at;
    } vec_t;

    vec_t vecs[9];

    rsa_modexp_ctrl #(.NBITS(NB), .EXP_WIDTH(EW), .EARLY_EXIT(1'b0)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .start(start), .abort(abort), .expE(expE),
        .rst_mmm(a_rst_mmm), .ld_a(a_ld_a), .ld_r(a_ld_r), .lock1(a_lock1), .lock2(a_lock2),
        .sel1(a_sel1), .sel2(a_sel2), .busy(a_busy), .eoc(a_eoc)
    );

    rsa_modexp_ctrl #(.NBITS(NB), .EXP_WIDTH(EW), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .rstb(rstb), .ena(ena), .start(start), .abort(abort), .expE(expE),
        .rst_mmm(b_rst_mmm), .ld_a(b_ld_a), .ld_r(b_ld_r), .lock1(b_lock1), .lock2(b_lock2),
        .sel1(b_sel1), .sel2(b_sel2), .busy(b_busy), .eoc(b_eoc)
    );

    assign ov_a = {a_rst_mmm, a_ld_a, a_ld_r, a_lock1, a_lock2, a_sel1, a_sel2, a_busy, a_eoc};
    assign ov_b = {b_rst_mmm, b_ld_a, b_ld_r, b_lock1, b_lock2, b_sel1, b_sel2, b_busy, b_eoc};

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] outv(input bit ee);
        return ee ? ov_b : ov_a;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((a_busy || b_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({name, " idle_timeout"}, 1, 0);
    endtask

    // Pulse start, then walk the run until eoc, collecting latency, ld_r pulses and per-round lock1
    task automatic run(input vec_t v, input string tag);
        int         k, ldr, rnd;
        bit         busy_ok;
        logic [3:0] pat;
        logic [9:0] o;
        @(negedge clk);
        expE  = v.e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; ldr = 0; rnd = 0; pat = '0; busy_ok = 1'b1;
        o = outv(v.ee);
        check({tag, " first_cycle_outputs"}, int'(o), int'(V_PRE_MAP));
        forever begin
            o = outv(v.ee);
            if (o[0] || k >= 200) break;
            if (!o[1]) busy_ok = 1'b0;
            if (o[7]) begin
                ldr++;
                if (o[4:3] == 2'b01 && rnd < 4) begin
                    pat[rnd] = o[6];
                    rnd++;
                end
            end
            if (k == v.ena_at)         ena = 1'b0;
            if (k == v.ena_at + 5)     ena = 1'b1;
            if (k == v.bstart_at)      begin start = 1'b1; expE = ~v.e; end
            if (k == v.bstart_at + 1)  begin start = 1'b0; expE = v.e; end
            @(negedge clk);
            k++;
        end
        ena = 1'b1;
        check({tag, " eoc_latency"}, k, v.lat);
        check({tag, " ld_r_pulses"}, ldr, v.ldr);
        check({tag, " lock1_rounds"}, int'(pat), int'(v.pat));
        check({tag, " busy_throughout"}, int'(busy_ok), 1);
        check({tag, " done_outputs"}, int'(outv(v.ee)), int'(V_DONE));
    endtask

    initial begin
        bit         seen;
        vec_t       v;
        rstb = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; expE = '0;

        //            e        ee lat ldr pat      ena bstart
        vecs[0] = '{4'b1011, 1'b0, 66, 6, 4'b1011, -10, -10};
        vecs[1] = '{4'b0000, 1'b0, 66, 6, 4'b0000, -10, -10};
        vecs[2] = '{4'b1111, 1'b0, 66, 6, 4'b1111, -10, -10};
        vecs[3] = '{4'b1011, 1'b0, 71, 6, 4'b1011,  25, -10};
        vecs[4] = '{4'b0110, 1'b0, 66, 6, 4'b0110, -10,  30};
        vecs[5] = '{4'b0011, 1'b1, 44, 4, 4'b0011, -10, -10};
        vecs[6] = '{4'b0000, 1'b1, 33, 3, 4'b0000, -10, -10};
        vecs[7] = '{4'b1000, 1'b1, 66, 6, 4'b1000, -10, -10};
        vecs[8] = '{4'b0100, 1'b1, 55, 5, 4'b0100, -10, -10};

        #12;
        check("reset_outputs_a", int'(ov_a), int'(V_IDLE));
        check("reset_outputs_b", int'(ov_b), int'(V_IDLE));
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        check("idle_after_reset", int'(ov_a), int'(V_IDLE));

        for (int i = 0; i < 9; i++) begin
            run(vecs[i], $sformatf("vec%0d", i));
            wait_idle($sformatf("vec%0d", i));
        end

        // Restart from DONE with a new exponent
        check("in_done_before_restart", int'(a_eoc), 1);
        v = '{4'b0101, 1'b0, 66, 6, 4'b0101, -10, -10};
        run(v, "restart_from_done");
        wait_idle("restart_from_done");

        // Abort during round 3
        @(negedge clk);
        expE = 4'b1011; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (36) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_a", int'(ov_a), int'(V_IDLE));
        check("abort_idle_b", int'(ov_b), int'(V_IDLE));
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (a_eoc || b_eoc) seen = 1'b1;
        end
        check("abort_no_eoc", int'(seen), 0);
        run(vecs[0], "after_abort");
        wait_idle("after_abort");

        // Asynchronous reset mid-REMAP
        @(negedge clk);
        expE = 4'b1011; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (58) @(negedge clk);
        check("remap_sel1_before_reset", int'(a_sel1), 2);
        #1 rstb = 1'b0;
        #1;
        check("async_reset_outputs", int'(ov_a), int'(V_IDLE));
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        check("idle_after_release", int'(ov_a), int'(V_IDLE));
        run(vecs[0], "after_reset");
        wait_idle("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
